// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and constants for the ALU program sequencer.
// Instruction word layout: {opcode[7:4], A[3:2], B[1:0]}.
package alu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StExec,
    StWait,
    StDone
  } state_e;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_ADD  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;
  localparam logic [3:0] OP_INC  = 4'd13;
  localparam logic [3:0] OP_DEC  = 4'd14;
  localparam logic [3:0] OP_RSUM = 4'd15;

  localparam int unsigned OP_MSB = 7;
  localparam int unsigned OP_LSB = 4;
  localparam int unsigned A_MSB  = 3;
  localparam int unsigned A_LSB  = 2;
  localparam int unsigned B_MSB  = 1;
  localparam int unsigned B_LSB  = 0;

endpackage

// File: rtl/alu_seq_ctrl_prescaler.sv
// Step prescaler: counts enabled cycles and flags the last of STEP_DIV.
// tc_o is combinational so the caller can advance on the same edge.
module seq_prescaler #(
  parameter int unsigned STEP_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(STEP_DIV + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == CntW'(STEP_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Program sequencer for the 2-bit ALU: buffers instructions, issues them
// one per step (prescaler or single-step) and captures each ALU result.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned STEP_DIV = 10_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en_i,
  input  logic [7:0]               load_data_i,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     single_i,
  input  logic                     step_i,
  output logic [3:0]               alu_op_o,
  output logic [1:0]               alu_a_o,
  output logic [1:0]               alu_b_o,
  input  logic [7:0]               alu_result_i,
  output logic [7:0]               result_o,
  output logic                     result_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(DEPTH):0]   prog_count_o,
  output logic [$clog2(DEPTH)-1:0] pc_o,
  output logic                     load_ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      instr_q, instr_d;
  logic [7:0]      result_q, result_d;
  logic            rv_q, rv_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            wr_en;
  logic            psc_clr, psc_en, psc_tc;
  logic [AW-1:0]   pc_nxt;
  logic [7:0]      mem_q [DEPTH];

  assign pc_nxt = pc_q + AW'(1);

  seq_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr_i(psc_clr),
    .en_i (psc_en),
    .tc_o (psc_tc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    result_d = result_q;
    rv_d     = 1'b0;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    psc_clr  = 1'b0;
    psc_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (load_en_i) begin
          if (cnt_q < CW'(DEPTH)) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (start_i && (cnt_q != '0)) begin
          pc_d    = '0;
          instr_d = mem_q[0];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (stop_i) begin
          pc_d    = '0;
          state_d = StIdle;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        // stop wins over the capture of this step
        if (stop_i) begin
          pc_d    = '0;
          state_d = StIdle;
        end else begin
          result_d = alu_result_i;
          rv_d     = 1'b1;
          if ({1'b0, pc_q} == cnt_q - CW'(1)) begin
            state_d = StDone;
          end else begin
            psc_clr = 1'b1;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (stop_i) begin
          pc_d    = '0;
          state_d = StIdle;
        end else begin
          psc_en = !single_i;
          if (single_i ? step_i : psc_tc) begin
            pc_d    = pc_nxt;
            instr_d = mem_q[pc_nxt];
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      cnt_q    <= '0;
      instr_q  <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[cnt_q[AW-1:0]] <= load_data_i;
    end
  end

  assign alu_op_o       = instr_q[OP_MSB:OP_LSB];
  assign alu_a_o        = instr_q[A_MSB:A_LSB];
  assign alu_b_o        = instr_q[B_MSB:B_LSB];
  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign prog_count_o   = cnt_q;
  assign pc_o           = pc_q;
  assign load_ovf_o     = ovf_q;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Program sequencer for the team's 2-bit ALU: holds a small buffer of ALU instructions {opcode, A, B} and issues them one at a time to the ALU, capturing each 8-bit result. Steps are paced by a prescaler, so results are human-visible at the 10 MHz system clock, or by an external single-step pulse. It sits between the input switches and the ALU, replacing direct switch-to-ALU wiring.

Parameters:
DEPTH, 8, number of program entries (power of 2, ≥2)
STEP_DIV, 10_000_000, clk cycles spent in WAIT between steps (≥1); counter width = clog2(STEP_DIV+1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
load_en  in  1  append load_data to the program (IDLE only)
load_data  in  8  {opcode[3:0], A[1:0], B[1:0]}
clear  in  1  empty the program (IDLE only)
start  in  1  begin execution at entry 0
stop  in  1  abort execution
single  in  1  1 = advance on step pulse instead of prescaler
step  in  1  single-step advance pulse
alu_op  out  4  opcode to ALU
alu_a  out  2  operand A to ALU
alu_b  out  2  operand B to ALU
alu_result  in  8  ALU output (combinational w.r.t. alu_*)
result  out  8  last captured ALU result
result_valid  out  1  one-cycle pulse when result updates
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last entry captured
prog_count  out  clog2(DEPTH)+1  number of loaded entries
pc  out  clog2(DEPTH)  index of entry currently issued
load_ovf  out  1  sticky: load attempted while full

Behaviour:
- Reset: state IDLE; all outputs 0; prog_count 0; prescaler 0; buffer contents don't-care.
- FSM states: IDLE, ISSUE, EXEC, WAIT, DONE.
- IDLE priority per cycle: clear > load_en > start; only the highest-priority asserted input acts.
  - clear: prog_count←0, load_ovf←0.
  - load_en: if prog_count<DEPTH, entry[prog_count]←load_data and prog_count+1; else load_ovf←1, buffer unchanged.
  - start: if prog_count>0, pc←0, alu_*←entry[0], go ISSUE; if prog_count==0, ignore (stay IDLE, no done).
- ISSUE (1 cycle): alu_* stable, ALU settling; go EXEC.
- EXEC (1 cycle): result←alu_result, result_valid pulses next cycle. If pc==prog_count-1 go DONE, else go WAIT with prescaler cleared.
- WAIT: single=0: count STEP_DIV cycles, then pc+1, alu_*←entry[pc+1], go ISSUE. single=1: prescaler held; the first cycle with step=1 does the same advance. single is sampled every WAIT cycle, so switching modes mid-WAIT is allowed.
- DONE (1 cycle): done=1; go IDLE. alu_*, result and pc hold last values; program retained, so start re-runs it.
- Latency: start sampled at edge E0 → alu_* valid after E0 → result/result_valid after E2. Step period = STEP_DIV+2 cycles.
- stop in ISSUE/EXEC/WAIT: next state IDLE, pc←0, no result_valid or done for the aborted step, result holds. stop beats the EXEC capture in the same cycle. stop is ignored in IDLE and DONE.
- load_en, clear and start while busy: ignored; load_ovf unaffected.
- Opcode 1111 (running-sum) is issued like any other opcode; the controller samples whatever the ALU presents in EXEC.
- pc never exceeds prog_count-1; prog_count saturates at DEPTH.

Decomposition:
- Shared package: FSM state enum; opcode constants (OP_AND=0 … OP_RSUM=15); instruction field slice positions (OP 7:4, A 3:2, B 1:0).
- One natural sub-module: seq_prescaler (clear/enable/terminal-count pulse, parameter STEP_DIV). Buffer and FSM live in alu_seq_ctrl.

Test Plan:
- STEP_DIV=4, bench wires alu_* to the team ALU. Load 0x76 (add 2+1), 0x9F (mul 3×3), 0xA6 (cmp 1 vs 2); start → result_valid pulses carry 0x03, 0x09, 0x01 spaced 6 cycles apart, first 3 edges after start; done one cycle after third; busy low after.
- Load DEPTH+1 entries → prog_count=DEPTH, load_ovf=1, last entry unchanged; clear → prog_count=0, load_ovf=0; start → stays IDLE, no done.
- single=1, program of 2 entries; no step for 100 cycles → pc=0, one result_valid only; step pulse → second result 2 cycles later, then done.
- stop asserted during second entry's EXEC → no result_valid, IDLE next cycle, pc=0, result still holds first value.
- rst asserted mid-WAIT (asynchronous, between edges) → all outputs 0 immediately; prog_count=0; start afterwards ignored.
- clear, load_en and start asserted in the same IDLE cycle → only clear acts; start with load_en → entry appended, no execution.
